// File: rtl/control_unit.sv
// rtl/control_unit.sv - BIP control unit: PC, run/halt FSM, instruction decode and retired-instruction counter
module control_unit #(
  parameter int NBITS_PC      = 11,
  parameter int NBITS_OPC     = 5,
  parameter int NBITS_OPERAND = 11,
  parameter int NBITS_CYC     = 32
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_Start,
  input  logic                     i_Enable,
  input  logic [15:0]              i_Instruction,
  output logic [NBITS_PC-1:0]      o_PC,
  output logic [NBITS_OPERAND-1:0] o_Operand,
  output logic [1:0]               o_SelA,
  output logic                     o_SelB,
  output logic                     o_WrAcc,
  output logic                     o_Op,
  output logic                     o_WrRam,
  output logic                     o_RdRam,
  output logic                     o_Halted,
  output logic [NBITS_CYC-1:0]     o_Cycles
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [NBITS_OPC-1:0] OPC_HLT  = 5'b00000;
  localparam logic [NBITS_OPC-1:0] OPC_STO  = 5'b00001;
  localparam logic [NBITS_OPC-1:0] OPC_LD   = 5'b00010;
  localparam logic [NBITS_OPC-1:0] OPC_LDI  = 5'b00011;
  localparam logic [NBITS_OPC-1:0] OPC_ADD  = 5'b00100;
  localparam logic [NBITS_OPC-1:0] OPC_ADDI = 5'b00101;
  localparam logic [NBITS_OPC-1:0] OPC_SUB  = 5'b00110;
  localparam logic [NBITS_OPC-1:0] OPC_SUBI = 5'b00111;

  state_t               state;
  logic [NBITS_OPC-1:0] opcode;
  logic                 active;

  assign opcode    = i_Instruction[15:11];
  assign o_Operand = i_Instruction[NBITS_OPERAND-1:0];
  // Strobes derive from the registered state, so async reset silences them at once.
  assign active    = (state == RUN) && i_Enable;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      o_PC     <= '0;
      o_Cycles <= '0;
      o_Halted <= 1'b0;
    end else if (i_Enable) begin
      case (state)
        IDLE: begin
          if (i_Start) begin
            state    <= RUN;
            o_PC     <= '0;
            o_Cycles <= '0;
          end
        end
        RUN: begin
          o_Cycles <= o_Cycles + 1'b1;
          if (opcode == OPC_HLT) begin
            state    <= HALT;
            o_Halted <= 1'b1;
          end else begin
            o_PC <= o_PC + 1'b1;
          end
        end
        HALT: begin
          if (i_Start) begin
            state    <= RUN;
            o_PC     <= '0;
            o_Cycles <= '0;
            o_Halted <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_SelA  = 2'b00;
    o_SelB  = 1'b0;
    o_WrAcc = 1'b0;
    o_Op    = 1'b0;
    o_WrRam = 1'b0;
    o_RdRam = 1'b0;
    if (active) begin
      case (opcode)
        OPC_STO:  o_WrRam = 1'b1;
        OPC_LD: begin
          o_RdRam = 1'b1;
          o_WrAcc = 1'b1;
        end
        OPC_LDI: begin
          o_SelA  = 2'b01;
          o_WrAcc = 1'b1;
        end
        OPC_ADD: begin
          o_RdRam = 1'b1;
          o_SelA  = 2'b10;
          o_WrAcc = 1'b1;
        end
        OPC_ADDI: begin
          o_SelB  = 1'b1;
          o_SelA  = 2'b10;
          o_WrAcc = 1'b1;
        end
        OPC_SUB: begin
          o_RdRam = 1'b1;
          o_Op    = 1'b1;
          o_SelA  = 2'b10;
          o_WrAcc = 1'b1;
        end
        OPC_SUBI: begin
          o_SelB  = 1'b1;
          o_Op    = 1'b1;
          o_SelA  = 2'b10;
          o_WrAcc = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
module tb_control_unit;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_Start;
  logic        i_Enable;
  logic [15:0] i_Instruction;
  logic [10:0] o_PC;
  logic [10:0] o_Operand;
  logic [1:0]  o_SelA;
  logic        o_SelB;
  logic        o_WrAcc;
  logic        o_Op;
  logic        o_WrRam;
  logic        o_RdRam;
  logic        o_Halted;
  logic [31:0] o_Cycles;

  logic [15:0] mem [0:2047];
  logic [6:0]  strobes;
  int          checks = 0;
  int          errors = 0;

  // strobe pack: {SelA[1:0], SelB, WrAcc, Op, WrRam, RdRam}
  localparam logic [6:0] S_NONE = 7'b00_0_0_0_0_0;
  localparam logic [6:0] S_STO  = 7'b00_0_0_0_1_0;
  localparam logic [6:0] S_LDI  = 7'b01_0_1_0_0_0;
  localparam logic [6:0] S_ADD  = 7'b10_0_1_0_0_1;
  localparam logic [6:0] S_ADDI = 7'b10_1_1_0_0_0;
  localparam logic [6:0] S_SUBI = 7'b10_1_1_1_0_0;

  logic [6:0]  prog_strb [0:4];
  logic [10:0] prog_opnd [0:4];

  control_unit dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_Start(i_Start), .i_Enable(i_Enable),
    .i_Instruction(i_Instruction), .o_PC(o_PC), .o_Operand(o_Operand),
    .o_SelA(o_SelA), .o_SelB(o_SelB), .o_WrAcc(o_WrAcc), .o_Op(o_Op),
    .o_WrRam(o_WrRam), .o_RdRam(o_RdRam), .o_Halted(o_Halted), .o_Cycles(o_Cycles)
  );

  always #5 i_clock = ~i_clock;
  assign i_Instruction = mem[o_PC];
  assign strobes = {o_SelA, o_SelB, o_WrAcc, o_Op, o_WrRam, o_RdRam};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_prog(input logic [4:0] opc3);
    for (int a = 0; a < 2048; a++) mem[a] = 16'h0000;
    mem[0] = {5'b00011, 11'd5};
    mem[1] = {5'b00101, 11'd3};
    mem[2] = {5'b00001, 11'd7};
    mem[3] = {opc3, 11'd1};
    mem[4] = {5'b00000, 11'd0};
  endtask

  task automatic pulse_start();
    @(negedge i_clock);
    i_Start = 1'b1;
    @(negedge i_clock);
    i_Start = 1'b0;
    chk("start_pc", 32'(o_PC), 32'd0);
    chk("start_cycles", o_Cycles, 32'd0);
    chk("start_halted", 32'(o_Halted), 32'd0);
  endtask

  // Starts right after pulse_start (at a negedge, state RUN, PC 0).
  task automatic run_prog(input bit step);
    for (int i = 0; i < 5; i++) begin
      if (step) begin
        i_Enable = 1'b0;
        #1;
        chk($sformatf("step_off_strb%0d", i), 32'(strobes), 32'(S_NONE));
        @(negedge i_clock);
        chk($sformatf("step_off_pc%0d", i), 32'(o_PC), i);
        i_Enable = 1'b1;
        #1;
      end
      chk($sformatf("pc%0d", i), 32'(o_PC), i);
      chk($sformatf("strb%0d", i), 32'(strobes), 32'(prog_strb[i]));
      if (i < 4) chk($sformatf("opnd%0d", i), 32'(o_Operand), 32'(prog_opnd[i]));
      @(negedge i_clock);
    end
    chk("halt_flag", 32'(o_Halted), 32'd1);
    chk("halt_pc", 32'(o_PC), 32'd4);
    chk("halt_cycles", o_Cycles, 32'd5);
  endtask

  initial begin
    logic any_strobe;
    prog_strb[0] = S_LDI;  prog_strb[1] = S_ADDI; prog_strb[2] = S_STO;
    prog_strb[3] = S_SUBI; prog_strb[4] = S_NONE;
    prog_opnd[0] = 11'd5;  prog_opnd[1] = 11'd3;  prog_opnd[2] = 11'd7;
    prog_opnd[3] = 11'd1;  prog_opnd[4] = 11'd0;
    load_prog(5'b00111);

    i_reset = 1'b0; i_Start = 1'b0; i_Enable = 1'b1;
    #1;
    chk("rst_pc", 32'(o_PC), 32'd0);
    chk("rst_cycles", o_Cycles, 32'd0);
    chk("rst_halted", 32'(o_Halted), 32'd0);
    chk("rst_strb", 32'(strobes), 32'(S_NONE));
    repeat (2) @(negedge i_clock);
    i_reset = 1'b1;
    repeat (5) @(negedge i_clock);
    chk("idle_pc", 32'(o_PC), 32'd0);
    chk("idle_cycles", o_Cycles, 32'd0);
    chk("idle_halted", 32'(o_Halted), 32'd0);
    chk("idle_strb", 32'(strobes), 32'(S_NONE));

    pulse_start();
    run_prog(1'b0);
    repeat (10) @(negedge i_clock);
    chk("hold_pc", 32'(o_PC), 32'd4);
    chk("hold_cycles", o_Cycles, 32'd5);
    chk("hold_halted", 32'(o_Halted), 32'd1);
    chk("hold_strb", 32'(strobes), 32'(S_NONE));

    pulse_start();
    run_prog(1'b0);
    pulse_start();
    run_prog(1'b1);

    for (int a = 0; a < 2048; a++) mem[a] = {5'b01000, 11'(a)};
    pulse_start();
    any_strobe = 1'b0;
    for (int c = 1; c <= 2049; c++) begin
      any_strobe = any_strobe | (|strobes);
      @(negedge i_clock);
      if (c == 2047) chk("wrap_pc2047", 32'(o_PC), 32'd2047);
      if (c == 2048) chk("wrap_pc0", 32'(o_PC), 32'd0);
    end
    chk("nop_strb", 32'(any_strobe), 32'd0);
    chk("wrap_pc1", 32'(o_PC), 32'd1);
    chk("wrap_cycles", o_Cycles, 32'd2049);

    i_reset = 1'b0;
    #1;
    chk("rst2_pc", 32'(o_PC), 32'd0);
    @(negedge i_clock);
    i_reset = 1'b1;
    load_prog(5'b00100);
    pulse_start();
    repeat (3) @(negedge i_clock);
    chk("mid_pc3", 32'(o_PC), 32'd3);
    chk("mid_add", 32'(strobes), 32'(S_ADD));
    #2;
    i_reset = 1'b0;
    #1;
    chk("mid_rst_strb", 32'(strobes), 32'(S_NONE));
    chk("mid_rst_pc", 32'(o_PC), 32'd0);
    @(negedge i_clock);
    i_reset = 1'b1;
    repeat (3) @(negedge i_clock);
    chk("mid_idle_strb", 32'(strobes), 32'(S_NONE));
    chk("mid_idle_pc", 32'(o_PC), 32'd0);
    pulse_start();
    chk("mid_rerun_strb", 32'(strobes), 32'(S_LDI));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction-sequencing and decode stage of the BIP accumulator datapath, directly upstream of the accumulator/operand multiplexer stage. Holds the program counter and a run/halt state machine. Decodes the 16-bit instruction word into the select, write-enable and ALU-operation strobes that steer the accumulator multiplexer, the ALU and data memory. Also exposes an executed-instruction counter for the debug unit.

## Interface
Parameters:
- NBITS_PC, 11, program counter width (instruction memory address)
- NBITS_OPC, 5, opcode field width (instruction bits [15:11])
- NBITS_OPERAND, 11, operand field width (instruction bits [10:0])
- NBITS_CYC, 32, executed-instruction counter width

Ports:
- i_clock  in  1  single clock; all state updates on the rising edge
- i_reset  in  1  reset, asynchronous, active-low
- i_Start  in  1  start/restart program; sampled in IDLE and HALT
- i_Enable  in  1  step enable from debug unit; 0 freezes all state and zeroes strobes
- i_Instruction  in  16  instruction at o_PC (instruction memory reads asynchronously)
- o_PC  out  NBITS_PC  instruction memory address
- o_Operand  out  NBITS_OPERAND  instruction bits [10:0], to sign extension and data memory address
- o_SelA  out  2  accumulator source: 00 data memory, 01 extended operand, 10 ALU
- o_SelB  out  1  ALU B operand: 0 data memory, 1 extended operand
- o_WrAcc  out  1  accumulator write enable
- o_Op  out  1  ALU operation: 0 add, 1 subtract
- o_WrRam  out  1  data memory write strobe
- o_RdRam  out  1  data memory read strobe
- o_Halted  out  1  high in HALT state
- o_Cycles  out  NBITS_CYC  number of instructions retired since last start

## Operation
- States: IDLE (reset state), RUN, HALT.
- IDLE: i_Start=1 -> RUN at next edge; o_PC stays 0.
- RUN, i_Enable=1: instruction executes this cycle; at the edge PC <= PC+1 and o_Cycles <= o_Cycles+1, except HLT.
- RUN, HLT fetched with i_Enable=1: -> HALT at the edge; PC not incremented; o_Cycles incremented (HLT counts as retired).
- RUN, i_Enable=0: state, PC and counter hold; all strobes 0.
- HALT: holds PC and counter; i_Start=1 -> PC <= 0, o_Cycles <= 0, -> RUN.
- i_Start in RUN ignored.
- Decode (only in RUN with i_Enable=1; otherwise every strobe is 0 and o_SelA=00):
  - 00000 HLT: all strobes 0
  - 00001 STO: WrRam=1
  - 00010 LD: RdRam=1, SelA=00, WrAcc=1
  - 00011 LDI: SelA=01, WrAcc=1
  - 00100 ADD: RdRam=1, SelB=0, Op=0, SelA=10, WrAcc=1
  - 00101 ADDI: SelB=1, Op=0, SelA=10, WrAcc=1
  - 00110 SUB: RdRam=1, SelB=0, Op=1, SelA=10, WrAcc=1
  - 00111 SUBI: SelB=1, Op=1, SelA=10, WrAcc=1
  - 01000-11111: NOP; strobes 0, PC and counter advance as normal.
- o_Operand is i_Instruction[10:0] unconditionally.
- Arithmetic: PC is unsigned modulo 2^NBITS_PC (2047 -> 0 for default); o_Cycles is unsigned modulo 2^NBITS_CYC.

## Timing
- Reset (i_reset=0, asynchronous): state IDLE, o_PC=0, o_Cycles=0, o_Halted=0; all strobes 0 immediately, without a clock edge.
- Reset asserted mid-program aborts the current instruction; strobes drop to 0 asynchronously.
- Reset release: first state change no earlier than the first rising edge with i_reset=1.
- Decode is combinational from i_Instruction and state; strobes are valid in the same cycle o_PC presents the address. There is one instruction per enabled cycle.
- o_PC, o_Cycles and o_Halted are registered; they change one edge after the triggering condition.
- o_Halted rises on the edge that consumes HLT. It falls on the edge that consumes i_Start in HALT.

## Test plan
- Reset/idle: hold i_reset=0, then release with i_Start=0 for 5 cycles -> o_PC=0, o_Cycles=0, all strobes 0, o_Halted=0.
- Program LDI 5, ADDI 3, STO 7, SUBI 1, HLT at addresses 0-4, i_Enable=1, pulse i_Start -> per-cycle strobes match the decode list. o_Operand = 5, 3, 7, 1. HALT entered with o_PC=4 and o_Cycles=5, then held for 10 cycles.
- Stepping: same program with i_Enable toggled 1,0,1,0 -> PC advances only on enabled cycles, and strobes are 0 in disabled cycles.
- Restart: pulse i_Start in HALT -> next edge o_PC=0, o_Cycles=0, o_Halted=0, and execution repeats identically.
- Wrap/NOP: fill memory with opcode 01000 and run 2049 cycles -> o_PC wraps 2047 -> 0 -> 1. All strobes stay 0 and o_Cycles=2049.
- Mid-run reset: assert i_reset during the ADD at PC=3 -> strobes 0 immediately, o_PC=0, and state is IDLE; i_Start is required to run again.
